// File: rtl/data_mem_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_dump_pkg
//  Description : Shared encodings for the Data_Memory dump master.
//                - Read/write enable encodings (shared with Data_Memory)
//                - Byte/halfword/word widths
//                - Dump FSM state encodings
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_dump_pkg;

    // Access widths
    localparam int c_BYTE     = 8;
    localparam int c_HALFWORD = 16;
    localparam int c_WORD     = 32;

    // Data_Memory read-enable encodings
    localparam logic [1:0] c_READ_DISABLE  = 2'b00;
    localparam logic [1:0] c_READ_BYTE     = 2'b01;
    localparam logic [1:0] c_READ_HALFWORD = 2'b10;
    localparam logic [1:0] c_READ_WORD     = 2'b11;

    // Data_Memory write-enable encodings (the dump master never writes)
    localparam logic [1:0] c_WRITE_DISABLE  = 2'b00;
    localparam logic [1:0] c_WRITE_BYTE     = 2'b01;
    localparam logic [1:0] c_WRITE_HALFWORD = 2'b10;
    localparam logic [1:0] c_WRITE_WORD     = 2'b11;

    // Dump FSM states
    localparam int         c_STATE_W  = 3;
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_REQ   = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_SEND  = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;
    localparam logic [2:0] c_ST_CHECK = 3'd5;

endpackage : data_mem_dump_pkg
`default_nettype wire

// File: rtl/data_mem_dump_ser.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_dump_ser
//  Description : 32-bit to 8-bit MSB-first serialiser with valid/ready output.
//                Optional macro DATA_MEM_DUMP_CHECKSUM_EN adds a running XOR
//                of every accepted byte and a single-byte checksum load.
//  Ports       : i_clk, i_rst            clock, synchronous active-high reset
//                i_load, i_load_word     load a word, start sending 4 bytes
//                i_clear_sum, i_load_sum checksum clear / checksum send (opt.)
//                i_tx_ready              downstream ready
//                o_tx_data, o_tx_valid   byte stream
//                o_last_byte_accepted    final byte of current load accepted
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_dump_ser
    import data_mem_dump_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic [c_WORD-1:0]   i_load_word,
`ifdef DATA_MEM_DUMP_CHECKSUM_EN
    input  logic                i_clear_sum,
    input  logic                i_load_sum,
`endif
    input  logic                i_tx_ready,
    output logic [c_BYTE-1:0]   o_tx_data,
    output logic                o_tx_valid,
    output logic                o_last_byte_accepted
);

    logic [c_WORD-1:0] r_shreg;
    logic [1:0]        r_byte_idx;
    logic              r_valid;
    logic              w_accept;

    assign w_accept             = r_valid & i_tx_ready;
    assign o_last_byte_accepted = w_accept & (r_byte_idx == 2'd3);
    assign o_tx_data            = r_shreg[c_WORD-1 -: c_BYTE];
    assign o_tx_valid           = r_valid;

`ifdef DATA_MEM_DUMP_CHECKSUM_EN
    logic [c_BYTE-1:0] r_sum;
    logic [c_BYTE-1:0] w_sum_next;

    // The checksum load coincides with the last data byte being accepted,
    // so the byte on the bus this cycle is folded in combinationally.
    assign w_sum_next = w_accept ? (r_sum ^ o_tx_data) : r_sum;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear_sum) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum_next;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shreg    <= '0;
            r_byte_idx <= 2'd0;
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_shreg    <= i_load_word;
            r_byte_idx <= 2'd0;
            r_valid    <= 1'b1;
`ifdef DATA_MEM_DUMP_CHECKSUM_EN
        end else if (i_load_sum) begin
            // Start at index 3 so exactly one byte goes out.
            r_shreg    <= {w_sum_next, {(c_WORD-c_BYTE){1'b0}}};
            r_byte_idx <= 2'd3;
            r_valid    <= 1'b1;
`endif
        end else if (w_accept) begin
            r_shreg    <= {r_shreg[c_WORD-c_BYTE-1:0], {c_BYTE{1'b0}}};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule : data_mem_dump_ser
`default_nettype wire

// File: rtl/data_mem_dump.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_dump
//  Description : Read-only debug master for Data_Memory. On a start pulse it
//                walks an inclusive (wrapping) word-address range, reads each
//                word and streams it as 4 bytes MSB first on valid/ready.
//                Optional macro DATA_MEM_DUMP_CHECKSUM_EN appends one XOR
//                checksum byte after the last word.
//  Ports       : i_clk, i_rst                  clock, sync active-high reset
//                i_start, i_first_addr, i_last_addr   dump request
//                o_mem_addr, o_mem_read_enable, i_mem_data  memory read port
//                o_tx_data, o_tx_valid, i_tx_ready          byte stream
//                o_busy, o_done                status
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_dump
    import data_mem_dump_pkg::*;
#(
    parameter int RAM_WIDTH  = 32,
    parameter int NB_DEPTH   = 10,
    parameter int RD_LATENCY = 1
)
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [NB_DEPTH-1:0]  i_first_addr,
    input  logic [NB_DEPTH-1:0]  i_last_addr,
    output logic [NB_DEPTH-1:0]  o_mem_addr,
    output logic [1:0]           o_mem_read_enable,
    input  logic [RAM_WIDTH-1:0] i_mem_data,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam logic [1:0]          c_LAT_LAST = 2'(RD_LATENCY - 1);
    localparam logic [NB_DEPTH-1:0] c_ADDR_ONE = {{(NB_DEPTH-1){1'b0}}, 1'b1};

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;
    logic [NB_DEPTH-1:0]  r_cur_addr;
    logic [NB_DEPTH-1:0]  r_last_addr;
    logic [1:0]           r_lat_cnt;

    logic w_start_accept;
    logic w_advance;
    logic w_load;
    logic w_last_byte_accepted;
`ifdef DATA_MEM_DUMP_CHECKSUM_EN
    logic w_load_sum;
`endif

    // ------------------------------------------------------------------
    // State register and address/latency bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= c_ST_IDLE;
            r_cur_addr  <= '0;
            r_last_addr <= '0;
            r_lat_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            if (w_start_accept) begin
                r_cur_addr  <= i_first_addr;
                r_last_addr <= i_last_addr;
            end else if (w_advance) begin
                // Natural modulo-2^NB_DEPTH wrap handles last < first.
                r_cur_addr <= r_cur_addr + c_ADDR_ONE;
            end
            if (r_state == c_ST_WAIT) begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
            end else begin
                r_lat_cnt <= 2'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_start_accept    = 1'b0;
        w_advance         = 1'b0;
        w_load            = 1'b0;
`ifdef DATA_MEM_DUMP_CHECKSUM_EN
        w_load_sum        = 1'b0;
`endif
        o_mem_addr        = '0;
        o_mem_read_enable = c_READ_DISABLE;
        o_busy            = 1'b1;
        o_done            = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_start_accept = 1'b1;
                    w_state_next   = c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                o_mem_addr        = r_cur_addr;
                o_mem_read_enable = c_READ_WORD;
                w_state_next      = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                // Address and enable held steady until the data is valid.
                o_mem_addr        = r_cur_addr;
                o_mem_read_enable = c_READ_WORD;
                if (r_lat_cnt == c_LAT_LAST) begin
                    w_load       = 1'b1;
                    w_state_next = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                if (w_last_byte_accepted) begin
                    if (r_cur_addr == r_last_addr) begin
`ifdef DATA_MEM_DUMP_CHECKSUM_EN
                        w_load_sum   = 1'b1;
                        w_state_next = c_ST_CHECK;
`else
                        w_state_next = c_ST_DONE;
`endif
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = c_ST_REQ;
                    end
                end
            end
`ifdef DATA_MEM_DUMP_CHECKSUM_EN
            c_ST_CHECK: begin
                if (w_last_byte_accepted) begin
                    w_state_next = c_ST_DONE;
                end
            end
`endif
            c_ST_DONE: begin
                o_busy       = 1'b0;
                o_done       = 1'b1;
                w_state_next = c_ST_IDLE;
            end
            default: begin
                o_busy       = 1'b0;
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte serialiser
    // ------------------------------------------------------------------
    data_mem_dump_ser u_ser (
        .i_clk                (i_clk),
        .i_rst                (i_rst),
        .i_load               (w_load),
        .i_load_word          (i_mem_data),
`ifdef DATA_MEM_DUMP_CHECKSUM_EN
        .i_clear_sum          (w_start_accept),
        .i_load_sum           (w_load_sum),
`endif
        .i_tx_ready           (i_tx_ready),
        .o_tx_data            (o_tx_data),
        .o_tx_valid           (o_tx_valid),
        .o_last_byte_accepted (w_last_byte_accepted)
    );

endmodule : data_mem_dump
`default_nettype wire
